// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES core between two job channels, with a stall watchdog.
// Optional key cache (skip key expansion on an unchanged key) enabled by AES_KEY_CACHE_EN.
module aes_job_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [1:0]   req_valid,
  input  logic [1:0]   req_ed,
  input  logic [127:0] req_data0,
  input  logic [127:0] req_data1,
  input  logic [127:0] req_key0,
  input  logic [127:0] req_key1,
  output logic [1:0]   req_ready,
  output logic [127:0] core_data,
  output logic [127:0] core_key,
  output logic         core_key_op,
  output logic         core_start_op,
  output logic         core_r_ready,
  output logic         core_ed_sel,
  input  logic         key_expanded,
  input  logic         aes_done,
  input  logic [127:0] core_data_out,
  output logic         resp_valid,
  output logic         resp_id,
  output logic         resp_err,
  output logic [127:0] resp_data,
  input  logic         resp_ready
);

  typedef enum logic [2:0] {StIdle, StKeyExp, StStart, StBusy, StResp} state_e;

  state_e       r_state, w_state_next;
  logic         r_rr;
  logic         r_id;
  logic         r_ed;
  logic [127:0] r_data;
  logic [127:0] r_key;
  logic [127:0] r_resp_data;
  logic         r_resp_err;
  logic [15:0]  r_wdog, w_wdog_next;

  logic [1:0]   w_grant;
  logic         w_accept;
  logic         w_sel;
  logic [127:0] w_sel_key;
  logic [127:0] w_sel_data;
  logic         w_need_kexp;
  logic         w_timing;
  logic         w_expired;
  logic         w_kexp_ok;
  logic         w_done_ok;
  logic         w_abort;

  always_comb begin
    case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_rr ? 2'b10 : 2'b01;
      default: w_grant = 2'b00;
    endcase
  end

  assign req_ready  = (r_state == StIdle) ? (req_valid & w_grant) : 2'b00;
  assign w_accept   = |req_ready;
  assign w_sel      = req_ready[1];
  assign w_sel_key  = w_sel ? req_key1 : req_key0;
  assign w_sel_data = w_sel ? req_data1 : req_data0;

  assign w_timing  = (r_state == StKeyExp) || (r_state == StBusy);
  assign w_expired = (r_wdog == 16'(TIMEOUT - 1));
  assign w_kexp_ok = (r_state == StKeyExp) && key_expanded;
  assign w_done_ok = (r_state == StBusy) && aes_done;
  // A core completion in the expiry cycle beats the watchdog.
  assign w_abort   = w_timing && w_expired && !w_kexp_ok && !w_done_ok;

`ifdef AES_KEY_CACHE_EN
  logic         r_cache_vld;
  logic [127:0] r_cache_key;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cache_vld <= 1'b0;
      r_cache_key <= '0;
    end else if (w_abort) begin
      r_cache_vld <= 1'b0;
    end else if (w_kexp_ok) begin
      r_cache_vld <= 1'b1;
      r_cache_key <= r_key;
    end
  end

  assign w_need_kexp = !r_cache_vld || (w_sel_key != r_cache_key);
`else
  assign w_need_kexp = 1'b1;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_next = w_need_kexp ? StKeyExp : StStart;
      StKeyExp: begin
        if (w_kexp_ok)    w_state_next = StStart;
        else if (w_abort) w_state_next = StResp;
      end
      StStart:  w_state_next = StBusy;
      StBusy:   if (w_done_ok || w_abort) w_state_next = StResp;
      StResp:   if (resp_ready) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_wdog_next = r_wdog;
    if ((w_state_next != r_state) &&
        ((w_state_next == StKeyExp) || (w_state_next == StBusy))) begin
      w_wdog_next = '0;
    end else if (w_timing) begin
      w_wdog_next = r_wdog + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= StIdle;
      r_wdog      <= '0;
      r_rr        <= 1'b0;
      r_id        <= 1'b0;
      r_ed        <= 1'b0;
      r_data      <= '0;
      r_key       <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wdog  <= w_wdog_next;
      if (w_accept) begin
        r_id   <= w_sel;
        r_ed   <= req_ed[w_sel];
        r_data <= w_sel_data;
        r_key  <= w_sel_key;
      end
      if (w_done_ok) begin
        r_resp_data <= core_data_out;
        r_resp_err  <= 1'b0;
      end else if (w_abort) begin
        r_resp_data <= '0;
        r_resp_err  <= 1'b1;
      end
      if ((r_state == StResp) && resp_ready) r_rr <= ~r_id;
    end
  end

  // Watchdog is cleared on KEY_EXP entry, so a zero count marks its first cycle.
  assign core_key_op   = (r_state == StKeyExp) && (r_wdog == '0);
  assign core_start_op = (r_state == StStart);
  assign core_r_ready  = (r_state == StStart);
  assign core_data     = r_data;
  assign core_key      = r_key;
  assign core_ed_sel   = r_ed;
  assign resp_valid    = (r_state == StResp);
  assign resp_id       = r_id;
  assign resp_err      = r_resp_err;
  assign resp_data     = r_resp_data;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Bench for aes_job_arbiter: emulates the AES core and checks each job against a
// transaction-level model of grants, key caching, latencies and watchdog aborts.
module tb_aes_job_arbiter;
  localparam int TO = 8;

  logic         clk;
  logic         n_rst;
  logic [1:0]   req_valid, req_ed, req_ready;
  logic [127:0] req_data0, req_data1, req_key0, req_key1;
  logic [127:0] core_data, core_key, core_data_out, resp_data;
  logic         core_key_op, core_start_op, core_r_ready, core_ed_sel;
  logic         key_expanded, aes_done;
  logic         resp_valid, resp_id, resp_err, resp_ready;

  aes_job_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ed(req_ed),
    .req_data0(req_data0), .req_data1(req_data1), .req_key0(req_key0), .req_key1(req_key1),
    .req_ready(req_ready), .core_data(core_data), .core_key(core_key),
    .core_key_op(core_key_op), .core_start_op(core_start_op), .core_r_ready(core_r_ready),
    .core_ed_sel(core_ed_sel), .key_expanded(key_expanded), .aes_done(aes_done),
    .core_data_out(core_data_out), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_err(resp_err), .resp_data(resp_data), .resp_ready(resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec, nerr;

  // Reference model state
  bit           m_rr, m_cvld;
  logic [127:0] m_ckey;

  // Observations of one job (cycle numbers relative to the job's first cycle)
  bit           ob_done, ob_unstable, ob_rdy_flight, ob_rr_bad;
  int           ob_acc_t, ob_ch, ob_nkey, ob_key_t, ob_nstart, ob_start_t, ob_resp_t, ob_nresp;
  logic         ob_id, ob_err;
  logic [127:0] ob_data;

  // Model expectations of one job
  int           ex_ch, ex_nkey, ex_start_t, ex_resp_t;
  logic         ex_err;
  logic [127:0] ex_data;

  // Stand-in for the AES transform
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k,
                                            input logic ed);
    return {d[95:0], d[127:96]} ^ k ^ {128{ed}} ^ 128'h5a;
  endfunction

  task automatic drive_idle();
    req_valid = 2'b00; aes_done = 1'b0; key_expanded = 1'b0; resp_ready = 1'b0;
  endtask

  task automatic model_reset();
    m_rr = 1'b0; m_cvld = 1'b0; m_ckey = '0;
  endtask

  task automatic model_job(input logic [1:0] valid, input int kexp_lat, input int done_lat);
    logic [127:0] key, data;
    logic         ed;
    bit           need;
    ex_ch = (valid == 2'b11) ? int'(m_rr) : (valid[1] ? 1 : 0);
    key   = (ex_ch == 1) ? req_key1 : req_key0;
    data  = (ex_ch == 1) ? req_data1 : req_data0;
    ed    = req_ed[ex_ch];
`ifdef AES_KEY_CACHE_EN
    need = !(m_cvld && (m_ckey == key));
`else
    need = 1'b1;
`endif
    ex_nkey = need ? 1 : 0;
    ex_err  = 1'b0;
    ex_data = '0;
    if (need && (kexp_lat == 0 || kexp_lat > TO - 1)) begin
      ex_start_t = -1; ex_resp_t = 1 + TO; ex_err = 1'b1; m_cvld = 1'b0;
    end else begin
      if (need) begin
        m_cvld = 1'b1; m_ckey = key; ex_start_t = kexp_lat + 2;
      end else begin
        ex_start_t = 1;
      end
      if (done_lat >= 1 && done_lat <= TO) begin
        ex_resp_t = ex_start_t + done_lat + 1; ex_data = core_fn(data, key, ed);
      end else begin
        ex_resp_t = ex_start_t + 1 + TO; ex_err = 1'b1; m_cvld = 1'b0;
      end
    end
    m_rr = (ex_ch == 0);
  endtask

  // Runs one job through the DUT acting as the AES core and response consumer.
  task automatic do_job(input logic [1:0] valid, input int kexp_lat, input int done_lat,
                        input int hold);
    int kexp_at, done_at;
    bit acc, seen_key, seen_start;
    ob_done = 0; ob_unstable = 0; ob_rdy_flight = 0; ob_rr_bad = 0; ob_acc_t = -1; ob_ch = -1;
    ob_nkey = 0; ob_key_t = -1; ob_nstart = 0; ob_start_t = -1; ob_resp_t = -1; ob_nresp = 0;
    ob_id = 1'b0; ob_err = 1'b0; ob_data = '0;
    kexp_at = -1; done_at = -1; acc = 0; seen_key = 0; seen_start = 0;
    for (int t = 0; t < 200 && !ob_done; t++) begin
      @(posedge clk); #1;
      req_valid    = valid;
      key_expanded = (t == kexp_at) || (seen_start && ($urandom_range(3) == 0));
      aes_done     = (t == done_at) || (seen_key && !seen_start && ($urandom_range(3) == 0));
      core_data_out = (t == done_at) ? core_fn(core_data, core_key, core_ed_sel)
                                     : {$urandom, $urandom, $urandom, $urandom};
      resp_ready   = resp_valid && (ob_nresp >= hold);
      #1;
      if (!acc && |req_ready) begin
        acc = 1; ob_acc_t = t; ob_ch = req_ready[1] ? 1 : 0;
      end else if (acc && |req_ready) begin
        ob_rdy_flight = 1;
      end
      if (core_key_op) begin
        ob_nkey++; ob_key_t = t; seen_key = 1;
        if (kexp_lat > 0) kexp_at = t + kexp_lat;
      end
      if (core_start_op) begin
        ob_nstart++; ob_start_t = t; seen_start = 1;
        if (done_lat > 0) done_at = t + done_lat;
      end
      if (core_start_op !== core_r_ready) ob_rr_bad = 1;
      if (resp_valid) begin
        if (ob_nresp == 0) begin
          ob_resp_t = t; ob_id = resp_id; ob_err = resp_err; ob_data = resp_data;
        end else if (resp_id !== ob_id || resp_err !== ob_err || resp_data !== ob_data) begin
          ob_unstable = 1;
        end
        if (resp_ready) ob_done = 1;
        ob_nresp++;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL rst_req_ready: got %b exp 00", req_ready); end
    nvec++; if (core_key_op !== 1'b0) begin nerr++; $display("FAIL rst_key_op: got %b exp 0", core_key_op); end
    nvec++; if (core_start_op !== 1'b0) begin nerr++; $display("FAIL rst_start_op: got %b exp 0", core_start_op); end
    nvec++; if (core_r_ready !== 1'b0) begin nerr++; $display("FAIL rst_r_ready: got %b exp 0", core_r_ready); end
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
    nvec++; if (resp_err !== 1'b0) begin nerr++; $display("FAIL rst_resp_err: got %b exp 0", resp_err); end
    nvec++; if (resp_id !== 1'b0) begin nerr++; $display("FAIL rst_resp_id: got %b exp 0", resp_id); end
    nvec++; if (core_data !== '0) begin nerr++; $display("FAIL rst_core_data: got %h exp 0", core_data); end
    nvec++; if (core_key !== '0) begin nerr++; $display("FAIL rst_core_key: got %h exp 0", core_key); end
    nvec++; if (resp_data !== '0) begin nerr++; $display("FAIL rst_resp_data: got %h exp 0", resp_data); end
    nvec++; if (core_ed_sel !== 1'b0) begin nerr++; $display("FAIL rst_ed_sel: got %b exp 0", core_ed_sel); end
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    req_key0 = {$urandom, $urandom, $urandom, $urandom};
    req_data0 = {$urandom, $urandom, $urandom, $urandom};
    req_ed = 2'b01;
    model_job(2'b01, 3, 6);
    do_job(2'b01, 3, 6, 0);
    nvec++; if (ob_done !== 1'b1) begin nerr++; $display("FAIL basic_done: got %0d exp 1", ob_done); end
    nvec++; if (ob_acc_t !== 0) begin nerr++; $display("FAIL basic_accept_t: got %0d exp 0", ob_acc_t); end
    nvec++; if (ob_nkey !== 1) begin nerr++; $display("FAIL basic_nkey: got %0d exp 1", ob_nkey); end
    nvec++; if (ob_key_t !== 1) begin nerr++; $display("FAIL basic_key_t: got %0d exp 1", ob_key_t); end
    nvec++; if (ob_nstart !== 1) begin nerr++; $display("FAIL basic_nstart: got %0d exp 1", ob_nstart); end
    nvec++; if (ob_start_t !== ex_start_t) begin nerr++; $display("FAIL basic_start_t: got %0d exp %0d", ob_start_t, ex_start_t); end
    nvec++; if (ob_resp_t !== ex_resp_t) begin nerr++; $display("FAIL basic_resp_t: got %0d exp %0d", ob_resp_t, ex_resp_t); end
    nvec++; if (ob_id !== 1'b0) begin nerr++; $display("FAIL basic_resp_id: got %b exp 0", ob_id); end
    nvec++; if (ob_err !== 1'b0) begin nerr++; $display("FAIL basic_resp_err: got %b exp 0", ob_err); end
    nvec++; if (ob_data !== ex_data) begin nerr++; $display("FAIL basic_resp_data: got %h exp %h", ob_data, ex_data); end
    nvec++; if (ob_rr_bad !== 1'b0) begin nerr++; $display("FAIL basic_r_ready: got %0d exp 0", ob_rr_bad); end
  endtask

  task automatic test_cached();
    req_data0 = {$urandom, $urandom, $urandom, $urandom};
    req_ed = 2'b00;
    model_job(2'b01, 3, 5);
    do_job(2'b01, 3, 5, 0);
    nvec++; if (ob_acc_t !== 0) begin nerr++; $display("FAIL cached_accept_t: got %0d exp 0", ob_acc_t); end
    nvec++; if (ob_nkey !== ex_nkey) begin nerr++; $display("FAIL cached_nkey: got %0d exp %0d", ob_nkey, ex_nkey); end
    nvec++; if (ob_start_t !== ex_start_t) begin nerr++; $display("FAIL cached_start_t: got %0d exp %0d", ob_start_t, ex_start_t); end
    nvec++; if (ob_resp_t !== ex_resp_t) begin nerr++; $display("FAIL cached_resp_t: got %0d exp %0d", ob_resp_t, ex_resp_t); end
    nvec++; if (ob_data !== ex_data) begin nerr++; $display("FAIL cached_resp_data: got %h exp %h", ob_data, ex_data); end
  endtask

  task automatic test_timeout();
    req_key1 = {$urandom, $urandom, $urandom, $urandom};
    req_data1 = {$urandom, $urandom, $urandom, $urandom};
    req_ed = 2'b10;
    model_job(2'b10, 2, 0);
    do_job(2'b10, 2, 0, 0);
    nvec++; if (ob_err !== 1'b1) begin nerr++; $display("FAIL to_busy_err: got %b exp 1", ob_err); end
    nvec++; if (ob_data !== '0) begin nerr++; $display("FAIL to_busy_data: got %h exp 0", ob_data); end
    nvec++; if (ob_id !== 1'b1) begin nerr++; $display("FAIL to_busy_id: got %b exp 1", ob_id); end
    nvec++; if (ob_resp_t - ob_start_t !== TO + 1) begin nerr++; $display("FAIL to_busy_latency: got %0d exp %0d", ob_resp_t - ob_start_t, TO + 1); end
    nvec++; if (ob_resp_t !== ex_resp_t) begin nerr++; $display("FAIL to_busy_resp_t: got %0d exp %0d", ob_resp_t, ex_resp_t); end
    // Same key again: the abort must have invalidated any cached schedule.
    model_job(2'b10, 1, 3);
    do_job(2'b10, 1, 3, 0);
    nvec++; if (ob_nkey !== 1) begin nerr++; $display("FAIL to_rekey_nkey: got %0d exp 1", ob_nkey); end
    nvec++; if (ob_data !== ex_data) begin nerr++; $display("FAIL to_rekey_data: got %h exp %h", ob_data, ex_data); end
    req_key1 = {$urandom, $urandom, $urandom, $urandom};
    model_job(2'b10, 0, 3);
    do_job(2'b10, 0, 3, 0);
    nvec++; if (ob_err !== 1'b1) begin nerr++; $display("FAIL to_kexp_err: got %b exp 1", ob_err); end
    nvec++; if (ob_nstart !== 0) begin nerr++; $display("FAIL to_kexp_nstart: got %0d exp 0", ob_nstart); end
    nvec++; if (ob_resp_t !== ex_resp_t) begin nerr++; $display("FAIL to_kexp_resp_t: got %0d exp %0d", ob_resp_t, ex_resp_t); end
    model_job(2'b10, 2, TO);
    do_job(2'b10, 2, TO, 0);
    nvec++; if (ob_err !== 1'b0) begin nerr++; $display("FAIL to_tie_err: got %b exp 0", ob_err); end
    nvec++; if (ob_data !== ex_data) begin nerr++; $display("FAIL to_tie_data: got %h exp %h", ob_data, ex_data); end
    model_job(2'b10, 2, TO + 1);
    do_job(2'b10, 2, TO + 1, 0);
    nvec++; if (ob_err !== 1'b1) begin nerr++; $display("FAIL to_late_err: got %b exp 1", ob_err); end
    nvec++; if (ob_resp_t !== ex_resp_t) begin nerr++; $display("FAIL to_late_resp_t: got %0d exp %0d", ob_resp_t, ex_resp_t); end
  endtask

  task automatic test_resp_hold();
    req_data0 = {$urandom, $urandom, $urandom, $urandom};
    req_data1 = {$urandom, $urandom, $urandom, $urandom};
    model_job(2'b11, 2, 4);
    do_job(2'b11, 2, 4, 5);
    nvec++; if (ob_done !== 1'b1) begin nerr++; $display("FAIL hold_done: got %0d exp 1", ob_done); end
    nvec++; if (ob_nresp !== 6) begin nerr++; $display("FAIL hold_resp_cycles: got %0d exp 6", ob_nresp); end
    nvec++; if (ob_unstable !== 1'b0) begin nerr++; $display("FAIL hold_stable: got %0d exp 0", ob_unstable); end
    nvec++; if (ob_rdy_flight !== 1'b0) begin nerr++; $display("FAIL hold_req_ready: got %0d exp 0", ob_rdy_flight); end
    nvec++; if (ob_data !== ex_data) begin nerr++; $display("FAIL hold_data: got %h exp %h", ob_data, ex_data); end
    nvec++; if (ob_ch !== ex_ch) begin nerr++; $display("FAIL hold_grant: got %0d exp %0d", ob_ch, ex_ch); end
  endtask

  task automatic test_reset_mid_job();
    bit started, bad;
    req_key0 = {$urandom, $urandom, $urandom, $urandom};
    req_data0 = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 2'b01;
    started = 0;
    for (int t = 0; t < 40 && !started; t++) begin
      @(posedge clk); #1;
      aes_done = 1'b0; resp_ready = 1'b0; key_expanded = core_key_op;
      #1;
      if (core_start_op) started = 1;
    end
    nvec++; if (started !== 1'b1) begin nerr++; $display("FAIL midrst_started: got %0d exp 1", started); end
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b0;
    drive_idle();
    #1;
    nvec++; if (core_data !== '0) begin nerr++; $display("FAIL midrst_core_data: got %h exp 0", core_data); end
    nvec++; if (core_key !== '0) begin nerr++; $display("FAIL midrst_core_key: got %h exp 0", core_key); end
    nvec++; if (core_ed_sel !== 1'b0) begin nerr++; $display("FAIL midrst_ed_sel: got %b exp 0", core_ed_sel); end
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL midrst_resp_valid: got %b exp 0", resp_valid); end
    nvec++; if (resp_data !== '0) begin nerr++; $display("FAIL midrst_resp_data: got %h exp 0", resp_data); end
    nvec++; if (resp_err !== 1'b0) begin nerr++; $display("FAIL midrst_resp_err: got %b exp 0", resp_err); end
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_reset();
    bad = 0;
    for (int t = 0; t < 15; t++) begin
      @(posedge clk); #1;
      aes_done = ($urandom_range(1) == 0); key_expanded = ($urandom_range(1) == 0);
      core_data_out = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (resp_valid || core_start_op || core_key_op) bad = 1;
    end
    nvec++; if (bad !== 1'b0) begin nerr++; $display("FAIL midrst_no_resp: got %0d exp 0", bad); end
    drive_idle();
  endtask

  task automatic test_alternate();
    req_key0 = {$urandom, $urandom, $urandom, $urandom};
    req_key1 = req_key0 ^ 128'h1;
    for (int i = 0; i < 4; i++) begin
      req_data0 = {$urandom, $urandom, $urandom, $urandom};
      req_data1 = {$urandom, $urandom, $urandom, $urandom};
      req_ed = 2'($urandom_range(3));
      model_job(2'b11, 2, 3);
      do_job(2'b11, 2, 3, 0);
      nvec++; if (ob_ch !== (i % 2)) begin nerr++; $display("FAIL alt_grant%0d: got %0d exp %0d", i, ob_ch, i % 2); end
      nvec++; if (ob_nkey !== 1) begin nerr++; $display("FAIL alt_nkey%0d: got %0d exp 1", i, ob_nkey); end
      nvec++; if (ob_data !== ex_data) begin nerr++; $display("FAIL alt_data%0d: got %h exp %h", i, ob_data, ex_data); end
      nvec++; if (ob_rdy_flight !== 1'b0) begin nerr++; $display("FAIL alt_req_ready%0d: got %0d exp 0", i, ob_rdy_flight); end
    end
  endtask

  task automatic test_random();
    logic [127:0] pool [3];
    logic [1:0]   valid;
    int           kl, dl, hl;
    for (int k = 0; k < 3; k++) pool[k] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 12; i++) begin
      valid = 2'($urandom_range(3, 1));
      req_key0 = pool[$urandom_range(2)];
      req_key1 = pool[$urandom_range(2)];
      req_data0 = {$urandom, $urandom, $urandom, $urandom};
      req_data1 = {$urandom, $urandom, $urandom, $urandom};
      req_ed = 2'($urandom_range(3));
      kl = ($urandom_range(9) == 0) ? 0 : $urandom_range(TO - 2, 1);
      dl = ($urandom_range(9) == 0) ? 0 : $urandom_range(TO + 2, 1);
      hl = $urandom_range(3);
      model_job(valid, kl, dl);
      do_job(valid, kl, dl, hl);
      nvec++; if (ob_done !== 1'b1) begin nerr++; $display("FAIL rnd%0d_done: got %0d exp 1", i, ob_done); end
      nvec++; if (ob_ch !== ex_ch) begin nerr++; $display("FAIL rnd%0d_grant: got %0d exp %0d", i, ob_ch, ex_ch); end
      nvec++; if (ob_id !== ex_ch[0]) begin nerr++; $display("FAIL rnd%0d_id: got %b exp %0d", i, ob_id, ex_ch); end
      nvec++; if (ob_nkey !== ex_nkey) begin nerr++; $display("FAIL rnd%0d_nkey: got %0d exp %0d", i, ob_nkey, ex_nkey); end
      nvec++; if (ob_start_t !== ex_start_t) begin nerr++; $display("FAIL rnd%0d_start_t: got %0d exp %0d", i, ob_start_t, ex_start_t); end
      nvec++; if (ob_resp_t !== ex_resp_t) begin nerr++; $display("FAIL rnd%0d_resp_t: got %0d exp %0d", i, ob_resp_t, ex_resp_t); end
      nvec++; if (ob_err !== ex_err) begin nerr++; $display("FAIL rnd%0d_err: got %b exp %b", i, ob_err, ex_err); end
      nvec++; if (ob_data !== ex_data) begin nerr++; $display("FAIL rnd%0d_data: got %h exp %h", i, ob_data, ex_data); end
      nvec++; if (ob_unstable || ob_rdy_flight || ob_rr_bad) begin nerr++; $display("FAIL rnd%0d_protocol: got %0d%0d%0d exp 000", i, ob_unstable, ob_rdy_flight, ob_rr_bad); end
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    n_rst = 1'b0;
    drive_idle();
    req_ed = 2'b00; req_data0 = '0; req_data1 = '0; req_key0 = '0; req_key1 = '0;
    core_data_out = '0;
    test_reset();
    test_basic();
    test_cached();
    test_timeout();
    test_resp_hold();
    test_reset_mid_job();
    test_alternate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
